// File: rtl/ai_move_scheduler.sv
// ai_move_scheduler: picks and commits the AI player's move on a 3x3 board.
//
// On start (sampled in IDLE only) the board is snapshotted. The eight winning lines
// are then scanned one per cycle, first for an immediate win and then for a block.
// If neither hits, the first empty cell in center, corner, edge order is taken.
// The chosen cell is written through a req/ack handshake.
//
// Build option: define AI_BLOCK_EN to include the SCAN_BLOCK pass. When it is
// undefined, a miss on the last win line goes straight to PICK.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   start    AI-turn request (sampled in IDLE)
//   board    18-bit board, cell k = row*3+col at bits [2k+1:2k]
//            (00 empty, 10 X, 01 O, 11 illegal)
//   wr_req   write request to the board port
//   wr_row   row of the chosen cell, valid while wr_req is high
//   wr_col   column of the chosen cell, valid while wr_req is high
//   wr_xoro  mark to write (AI_MARK while wr_req is high, else 00)
//   wr_ack   board accepted the write (only looked at in REQ)
//   busy     high in every state except IDLE
//   done     one-cycle pulse when the turn completes
//   no_move  one-cycle pulse with done when no empty cell exists
module ai_move_scheduler #(
  parameter logic [1:0] AI_MARK = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic        wr_req,
  output logic [1:0]  wr_row,
  output logic [1:0]  wr_col,
  output logic [1:0]  wr_xoro,
  input  logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic        no_move
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StScanWin   = 3'd1,
`ifdef AI_BLOCK_EN
    StScanBlock = 3'd2,
`endif
    StPick      = 3'd3,
    StReq       = 3'd4,
    StDone      = 3'd5
  } state_e;

`ifdef AI_BLOCK_EN
  localparam logic [1:0] OppMark = ~AI_MARK;
`endif

  // Fallback search order: center, corners, edges.
  localparam logic [3:0] PickOrder [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8,
                                           4'd1, 4'd3, 4'd5, 4'd7};

  state_e      state_q, state_d;
  logic [2:0]  line_q, line_d;
  logic [17:0] snap_q, snap_d;
  logic [3:0]  tgt_q, tgt_d;    // {row, col}
  logic        flag_q, flag_d;  // no empty cell found

  logic [1:0]  cells [9];
  logic [3:0]  c0, c1, c2;
  logic [1:0]  v0, v1, v2;
  logic [3:0]  hit_cell;
  logic        win_hit;
`ifdef AI_BLOCK_EN
  logic        blk_hit;
`endif
  logic        pick_found;
  logic [3:0]  pick_cell;

  // Two of the three cells carry mark m and the remaining one is empty. Code 11
  // never equals a mark and is not empty, so it always defeats a hit.
  function automatic logic line_hit(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] m);
    return (a == m && b == m && c == 2'b00) ||
           (a == m && c == m && b == 2'b00) ||
           (b == m && c == m && a == 2'b00);
  endfunction

  function automatic logic [3:0] cell_rc(input logic [3:0] idx);
    logic [3:0] rc;
    case (idx)
      4'd0:    rc = {2'd0, 2'd0};
      4'd1:    rc = {2'd0, 2'd1};
      4'd2:    rc = {2'd0, 2'd2};
      4'd3:    rc = {2'd1, 2'd0};
      4'd4:    rc = {2'd1, 2'd1};
      4'd5:    rc = {2'd1, 2'd2};
      4'd6:    rc = {2'd2, 2'd0};
      4'd7:    rc = {2'd2, 2'd1};
      4'd8:    rc = {2'd2, 2'd2};
      default: rc = 4'd0;
    endcase
    return rc;
  endfunction

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      cells[k] = snap_q[2*k +: 2];
    end
  end

  // Cells covered by the current line: rows, columns, then the two diagonals.
  always_comb begin
    unique case (line_q)
      3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
      3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
      3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
      3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
      3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
      3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
      3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
      3'd7: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
    endcase
  end

  assign v0       = cells[c0];
  assign v1       = cells[c1];
  assign v2       = cells[c2];
  assign win_hit  = line_hit(v0, v1, v2, AI_MARK);
`ifdef AI_BLOCK_EN
  assign blk_hit  = line_hit(v0, v1, v2, OppMark);
`endif
  // On a hit exactly one cell is empty; pick it.
  assign hit_cell = (v0 == 2'b00) ? c0 : ((v1 == 2'b00) ? c1 : c2);

  // Walk the priority list backwards so the earliest empty entry wins.
  always_comb begin
    pick_found = 1'b0;
    pick_cell  = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (cells[PickOrder[i]] == 2'b00) begin
        pick_found = 1'b1;
        pick_cell  = PickOrder[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    snap_d  = snap_q;
    tgt_d   = tgt_q;
    flag_d  = flag_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d  = board;
          line_d  = 3'd0;
          flag_d  = 1'b0;
          state_d = StScanWin;
        end
      end
      StScanWin: begin
        if (win_hit) begin
          tgt_d   = cell_rc(hit_cell);
          state_d = StReq;
        end else begin
          // Wraps 7 -> 0, ready for the next pass.
          line_d = line_q + 3'd1;
          if (line_q == 3'd7) begin
`ifdef AI_BLOCK_EN
            state_d = StScanBlock;
`else
            state_d = StPick;
`endif
          end
        end
      end
`ifdef AI_BLOCK_EN
      StScanBlock: begin
        if (blk_hit) begin
          tgt_d   = cell_rc(hit_cell);
          state_d = StReq;
        end else begin
          line_d = line_q + 3'd1;
          if (line_q == 3'd7) begin
            state_d = StPick;
          end
        end
      end
`endif
      StPick: begin
        if (pick_found) begin
          tgt_d   = cell_rc(pick_cell);
          state_d = StReq;
        end else begin
          flag_d  = 1'b1;
          state_d = StDone;
        end
      end
      StReq: begin
        if (wr_ack) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      line_q  <= 3'd0;
      snap_q  <= 18'd0;
      tgt_q   <= 4'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      snap_q  <= snap_d;
      tgt_q   <= tgt_d;
      flag_q  <= flag_d;
    end
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  always_comb begin
    wr_req  = (state_q == StReq);
    wr_row  = 2'b00;
    wr_col  = 2'b00;
    wr_xoro = 2'b00;
    if (wr_req) begin
      wr_row  = tgt_q[3:2];
      wr_col  = tgt_q[1:0];
      wr_xoro = AI_MARK;
    end
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    no_move = (state_q == StDone) && flag_q;
  end

endmodule

// File: tb/tb_ai_move_scheduler.sv
// Self-checking bench for ai_move_scheduler (AI_MARK = X = 2'b10).
// Expected turn outcomes are queued when a turn is launched and popped when the
// DUT finishes the turn. Latencies count edges after E0, the edge sampling start.
module tb_ai_move_scheduler;

`ifdef AI_BLOCK_EN
  localparam int PickLat = 17;
`else
  localparam int PickLat = 9;
`endif

  typedef struct packed {
    int         lat_req;
    int         lat_done;
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] xoro;
    logic       nm;
    logic       stable;
  } turn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] board;
  logic        wr_req;
  logic [1:0]  wr_row;
  logic [1:0]  wr_col;
  logic [1:0]  wr_xoro;
  logic        wr_ack;
  logic        busy;
  logic        done;
  logic        no_move;

  int    n_cmp = 0;
  int    n_fail = 0;
  turn_t sb [$];

  ai_move_scheduler #(
    .AI_MARK(2'b10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .board  (board),
    .wr_req (wr_req),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_xoro(wr_xoro),
    .wr_ack (wr_ack),
    .busy   (busy),
    .done   (done),
    .no_move(no_move)
  );

  always #5 clk = ~clk;

  function automatic turn_t exp_write(input int lat, input logic [1:0] row,
                                      input logic [1:0] col, input int ack_delay);
    turn_t t;
    t.lat_req  = lat;
    t.lat_done = lat + ack_delay + 1;
    t.row      = row;
    t.col      = col;
    t.xoro     = 2'b10;
    t.nm       = 1'b0;
    t.stable   = 1'b1;
    return t;
  endfunction

  function automatic turn_t exp_none(input int lat);
    turn_t t;
    t.lat_req  = -1;
    t.lat_done = lat;
    t.row      = 2'b00;
    t.col      = 2'b00;
    t.xoro     = 2'b00;
    t.nm       = 1'b1;
    t.stable   = 1'b1;
    return t;
  endfunction

  function automatic string fmt(input turn_t t);
    return $sformatf("req@%0d row=%0d col=%0d mark=%b done@%0d no_move=%b stable=%b",
                     t.lat_req, t.row, t.col, t.xoro, t.lat_done, t.nm, t.stable);
  endfunction

  // Drive start for one edge (E0); returns #1 after E0.
  task automatic launch(input logic [17:0] b);
    board = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follow a turn to its done pulse (bounded), acking ack_delay cycles after
  // wr_req first appears. Returns #1 after the edge that raised done.
  task automatic observe(input int ack_delay, output turn_t o);
    turn_t t;
    int    held;
    t.lat_req  = -1;
    t.lat_done = -1;
    t.row      = 2'b00;
    t.col      = 2'b00;
    t.xoro     = 2'b00;
    t.nm       = 1'b0;
    t.stable   = 1'b1;
    held       = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      wr_ack = 1'b0;
      if (done) begin
        t.lat_done = n;
        t.nm       = no_move;
        break;
      end
      if (wr_req) begin
        if (t.lat_req < 0) begin
          t.lat_req = n;
          t.row     = wr_row;
          t.col     = wr_col;
          t.xoro    = wr_xoro;
        end else if ({wr_row, wr_col, wr_xoro} !== {t.row, t.col, t.xoro}) begin
          t.stable = 1'b0;
        end
        if (held == ack_delay) wr_ack = 1'b1;
        held++;
      end
    end
    o = t;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({wr_req, wr_row, wr_col, wr_xoro, busy, done, no_move} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {wr_req, wr_row, wr_col, wr_xoro,
                                                     busy, done, no_move});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_win();
    logic [17:0] boards [4];
    int          lats [4];
    logic [1:0]  rows [4];
    logic [1:0]  cols [4];
    turn_t       o;
    turn_t       e;
    // row0 X X _ ; overlap row0/col0 ; diag {2,4,6} ; win on diag beats block on row2
    boards = '{18'h0000A, 18'h0008A, 18'h02020, 18'h05202};
    lats   = '{1, 1, 8, 7};
    rows   = '{2'd0, 2'd0, 2'd1, 2'd2};
    cols   = '{2'd2, 2'd2, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(exp_write(lats[i], rows[i], cols[i], 0));
      launch(boards[i]);
      observe(0, o);
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL win[%0d]: got %s / want %s", i, fmt(o), fmt(e));
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL win_done_pulse[%0d]: done,busy=%b want 00", i, {done, busy});
      end
    end
  endtask

  task automatic test_block();
    turn_t o;
    turn_t e;
`ifdef AI_BLOCK_EN
    sb.push_back(exp_write(10, 2'd1, 2'd2, 0));
`else
    sb.push_back(exp_write(PickLat, 2'd0, 2'd2, 0));
`endif
    launch(18'h00142);
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL block: got %s / want %s", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_pick_stall();
    turn_t o;
    turn_t e;
    sb.push_back(exp_write(PickLat, 2'd1, 2'd1, 5));
    launch(18'h00000);
    observe(5, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL pick_center_stall: got %s / want %s", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
    // Cells 0,2,4,6,8 illegal (11): first empty in priority order is cell 1.
    sb.push_back(exp_write(PickLat, 2'd0, 2'd1, 0));
    launch(18'h33333);
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL pick_edge: got %s / want %s", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full();
    turn_t       o;
    turn_t       e;
    logic [17:0] b;
    // c8..c0 = 11 01 10 10 01 01 11 10 10 : no empty cell, row0 is X X 11
    b = {2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
    sb.push_back(exp_none(PickLat));
    launch(b);
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL full_no_move: got %s / want %s", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, no_move, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL no_move_pulse: done,no_move,busy=%b want 000", {done, no_move, busy});
    end
  endtask

  task automatic test_snapshot();
    turn_t o;
    turn_t e;
    sb.push_back(exp_write(PickLat - 3, 2'd1, 2'd1, 0));
    launch(18'h00000);
    // Board now shows a win on row 0 and start is re-asserted mid-scan.
    board = 18'h0000A;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL snapshot_restart: got %s / want %s (latency from E3)", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    turn_t o;
    turn_t e;
    launch(18'h0000A);
    @(posedge clk);
    #1;
    n_cmp++;
    if (wr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_req: wr_req=%b want 1", wr_req);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({wr_req, wr_row, wr_col, wr_xoro, busy, done} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b want 0", {wr_req, wr_row, wr_col, wr_xoro,
                                                   busy, done});
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, wr_req, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_abandon: busy,wr_req,done=%b want 000", {busy, wr_req, done});
    end
    sb.push_back(exp_write(8, 2'd1, 2'd1, 0));
    launch(18'h02020);
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_rescan: got %s / want %s", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    turn_t o;
    turn_t e;
    sb.push_back(exp_write(1, 2'd0, 2'd2, 0));
    launch(18'h0000A);
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL b2b_first: got %s / want %s", fmt(o), fmt(e));
    end
    // In the done cycle now; hold start high from here.
    start = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ignored_in_done: busy=%b want 0", busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    sb.push_back(exp_write(1, 2'd0, 2'd2, 0));
    observe(0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL b2b_second: got %s / want %s", fmt(o), fmt(e));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    board  = 18'd0;
    wr_ack = 1'b0;
    #3;
    test_reset();
    test_win();
    test_block();
    test_pick_stall();
    test_full();
    test_snapshot();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
